// File: rtl/xnorpop_feeder.sv
// Bit-serial feeder for the XNOR-popcount path: parallel a/w word pairs in, one bit
// per clock out (MSB first), with frame tracking, underrun detection and a result strobe.
module xnorpop_feeder #(
  parameter int word_width = 64,
  parameter int pop_size   = 576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [word_width-1:0] a_word,
  input  logic [word_width-1:0] w_word,
  output logic                  a,
  output logic                  w,
  output logic                  bit_valid,
  output logic                  frame_done,
  output logic                  pop_strobe,
  output logic                  underrun
);

  localparam int words_per_frame = pop_size / word_width;
  localparam int bit_cw  = (word_width > 1) ? $clog2(word_width) : 1;
  localparam int word_cw = (words_per_frame > 1) ? $clog2(words_per_frame) : 1;
  localparam logic [bit_cw-1:0]  bit_last  = bit_cw'(word_width - 1);
  localparam logic [word_cw-1:0] word_last = word_cw'(words_per_frame - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [word_width-1:0] sh_a_q, sh_a_d;
  logic [word_width-1:0] sh_w_q, sh_w_d;
  logic [word_width-1:0] nb_a_q, nb_a_d;
  logic [word_width-1:0] nb_w_q, nb_w_d;
  logic                  nb_full_q, nb_full_d;
  logic [bit_cw-1:0]     bit_cnt_q, bit_cnt_d;
  logic [word_cw-1:0]    word_cnt_q, word_cnt_d;
  logic [1:0]            strobe_q, strobe_d;
  logic                  underrun_q, underrun_d;

  logic last_bit;
  logic accept;
  logic shifter_free;
  logic refill;
  logic direct_load;

  assign last_bit     = (state_q == SHIFT) && (bit_cnt_q == bit_last);
  assign accept       = in_valid && in_ready;
  assign shifter_free = (state_q == IDLE) || last_bit;
  assign refill       = last_bit && nb_full_q;
  // A parked word always wins the refill slot; in_ready is low then, so no conflict.
  assign direct_load  = accept && shifter_free && !refill;

  // State register: every register, payload included, clears on reset so a
  // dropped frame leaves nothing behind in the buffers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      sh_a_q     <= '0;
      sh_w_q     <= '0;
      nb_a_q     <= '0;
      nb_w_q     <= '0;
      nb_full_q  <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      strobe_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_a_q     <= sh_a_d;
      sh_w_q     <= sh_w_d;
      nb_a_q     <= nb_a_d;
      nb_w_q     <= nb_w_d;
      nb_full_q  <= nb_full_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state logic: shifting, counters, buffer movement and underrun detection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    sh_a_d     = sh_a_q;
    sh_w_d     = sh_w_q;
    nb_a_d     = nb_a_q;
    nb_w_d     = nb_w_q;
    nb_full_d  = nb_full_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    underrun_d = 1'b0;
    strobe_d   = {strobe_q[0], frame_done};

    if (state_q == SHIFT) begin
      sh_a_d = {sh_a_q[word_width-2:0], 1'b0};
      sh_w_d = {sh_w_q[word_width-2:0], 1'b0};
      if (last_bit) begin
        bit_cnt_d  = '0;
        word_cnt_d = (word_cnt_q == word_last) ? '0 : word_cnt_q + 1'b1;
      end else begin
        bit_cnt_d  = bit_cnt_q + 1'b1;
      end
    end

    if (refill) begin
      sh_a_d    = nb_a_q;
      sh_w_d    = nb_w_q;
      nb_full_d = 1'b0;
      state_d   = SHIFT;
    end else if (direct_load) begin
      sh_a_d  = a_word;
      sh_w_d  = w_word;
      state_d = SHIFT;
    end else begin
      if (accept) begin
        nb_a_d    = a_word;
        nb_w_d    = w_word;
        nb_full_d = 1'b1;
      end
      if (last_bit) begin
        state_d = IDLE;
        // Emptying away from a frame boundary abandons the partial frame.
        if (word_cnt_d != '0 || bit_cnt_d != '0) begin
          underrun_d = 1'b1;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    in_ready   = !nb_full_q && !reset;
    bit_valid  = (state_q == SHIFT);
    a          = bit_valid && sh_a_q[word_width-1];
    w          = bit_valid && sh_w_q[word_width-1];
    frame_done = last_bit && (word_cnt_q == word_last);
    pop_strobe = strobe_q[1];
    underrun   = underrun_q;
  end

endmodule
